// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement engine.
//   DIR_*       two-bit direction codes driven on dir_in
//   state_e     top-level game FSM state
//   step_t      per-axis two's-complement unit delta for one move
//   is_reverse  true when two directions point opposite ways
//   step        unit delta for a direction
package snake_pkg;

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    // 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } step_t;

    // Opposite directions share the axis bit and differ in the sign bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic step_t step(input logic [1:0] dir);
        step_t s;
        s = '0;
        case (dir)
            DIR_DOWN:  s.dy = 2'b01;
            DIR_UP:    s.dy = 2'b11;
            DIR_RIGHT: s.dx = 2'b01;
            default:   s.dx = 2'b11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Ring buffer of snake body segments with two parallel compare ports.
// Segment i of the snake lives in slot (head_ptr + i) mod MAX_LEN.
//   clk, reset      clock, synchronous active-high reset
//   init_i          reload the starting body (same effect as reset)
//   we_i/waddr_i    write a new head cell {wx_i, wy_i}
//   head_ptr_i      slot holding segment 0
//   head_x_o/y_o    cell of segment 0
//   a_* / b_*       compare ports: hit when any of the first *_cnt_i
//                   segments (counted from the head) equals {*_x_i, *_y_i}
module snake_seg_ram
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 4,
    parameter int START_Y   = 13,
    parameter int XW        = 6,
    parameter int YW        = 6,
    parameter int LW        = 5,
    parameter int PW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [XW-1:0] wx_i,
    input  logic [YW-1:0] wy_i,
    input  logic [PW-1:0] head_ptr_i,
    output logic [XW-1:0] head_x_o,
    output logic [YW-1:0] head_y_o,
    input  logic [XW-1:0] a_x_i,
    input  logic [YW-1:0] a_y_i,
    input  logic [LW-1:0] a_cnt_i,
    output logic          a_hit_o,
    input  logic [XW-1:0] b_x_i,
    input  logic [YW-1:0] b_y_i,
    input  logic [LW-1:0] b_cnt_i,
    output logic          b_hit_o
);

    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [PW-1:0] rel     [MAX_LEN];

    always_ff @(posedge clk) begin
        if (reset || init_i) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < START_LEN) ? XW'(START_LEN - 1 - i) : '0;
                seg_y_q[i] <= YW'(START_Y);
            end
        end else if (we_i) begin
            seg_x_q[waddr_i] <= wx_i;
            seg_y_q[waddr_i] <= wy_i;
        end
    end

    // Distance of each slot from the head, wrapping mod MAX_LEN.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            rel[i] = PW'(i) - head_ptr_i;
        end
    end

    always_comb begin
        a_hit_o = 1'b0;
        b_hit_o = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(rel[i]) < a_cnt_i) && (seg_x_q[i] == a_x_i) && (seg_y_q[i] == a_y_i))
                a_hit_o = 1'b1;
            if ((LW'(rel[i]) < b_cnt_i) && (seg_x_q[i] == b_x_i) && (seg_y_q[i] == b_y_i))
                b_hit_o = 1'b1;
        end
    end

    assign head_x_o = seg_x_q[head_ptr_i];
    assign head_y_o = seg_y_q[head_ptr_i];

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement engine: keeps the body in a ring buffer, moves one cell per
// tick, detects wall/self collisions, handles growth and answers registered
// per-cell occupancy queries for the pixel pipeline.
//   clk, reset            clock, synchronous active-high reset
//   tick                  one-cycle move strobe
//   start/pause/resume/esc game control pulses
//   dir_in                requested direction (00 down, 01 up, 10 right, 11 left)
//   grow                  lengthen on the next move
//   q_x, q_y              query cell; q_hit/q_head answer one cycle later
//   head_x, head_y        current head cell
//   length                current segment count
//   running, game_over    state == RUN / state == OVER
//
// state     | meaning
// ST_IDLE   | after reset, snake shown but not moving
// ST_RUN    | snake advances on tick
// ST_PAUSED | frozen, resume returns to RUN
// ST_OVER   | collision happened, only start/reset leave
module snake_body_engine
    import snake_pkg::*;
#(
    parameter  int GRID_W    = 64,
    parameter  int GRID_H    = 48,
    parameter  int MAX_LEN   = 16,
    parameter  int START_LEN = 4,
    parameter  int START_Y   = 13,
    localparam int XW        = $clog2(GRID_W),
    localparam int YW        = $clog2(GRID_H),
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          pause,
    input  logic          resume,
    input  logic          esc,
    input  logic [1:0]    dir_in,
    input  logic          grow,
    input  logic [XW-1:0] q_x,
    input  logic [YW-1:0] q_y,
    output logic          q_hit,
    output logic          q_head,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          running,
    output logic          game_over
);

    localparam int            PW       = $clog2(MAX_LEN);
    localparam logic [XW:0]   X_LIMIT  = (XW + 1)'(GRID_W);
    localparam logic [YW:0]   Y_LIMIT  = (YW + 1)'(GRID_H);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_INIT = LW'(START_LEN);

    state_e        state_q, state_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic [1:0]    ref_dir;
    logic          grow_pend_q, grow_pend_d;
    logic [LW-1:0] len_q, len_d;
    logic [PW-1:0] hptr_q, hptr_d;
    logic          q_hit_q, q_hit_d;
    logic          q_head_q, q_head_d;

    logic [XW-1:0] head_x_w;
    logic [YW-1:0] head_y_w;
    step_t         stp;
    logic [XW:0]   nx_w;
    logic [YW:0]   ny_w;
    logic          wall_w;
    logic          self_w;
    logic [LW-1:0] col_cnt;
    logic          move_req;
    logic          collide;
    logic          do_move;

    // Next head computed one bit wider so 0-1 lands above the limit.
    assign stp     = step(pend_dir_q);
    assign nx_w    = {1'b0, head_x_w} + {{(XW - 1){stp.dx[1]}}, stp.dx};
    assign ny_w    = {1'b0, head_y_w} + {{(YW - 1){stp.dy[1]}}, stp.dy};
    assign wall_w  = (nx_w >= X_LIMIT) || (ny_w >= Y_LIMIT);

    // The tail cell is vacated by a plain move, so it only counts when growing.
    assign col_cnt = grow_pend_q ? len_q : (len_q - LW'(1));

    assign move_req = (state_q == ST_RUN) && tick && !start && !pause && !esc;
    assign collide  = move_req && (wall_w || self_w);
    assign do_move  = move_req && !collide;

    snake_seg_ram #(
        .MAX_LEN   (MAX_LEN),
        .START_LEN (START_LEN),
        .START_Y   (START_Y),
        .XW        (XW),
        .YW        (YW),
        .LW        (LW),
        .PW        (PW)
    ) u_seg_ram (
        .clk        (clk),
        .reset      (reset),
        .init_i     (start),
        .we_i       (do_move),
        .waddr_i    (hptr_d),
        .wx_i       (nx_w[XW-1:0]),
        .wy_i       (ny_w[YW-1:0]),
        .head_ptr_i (hptr_q),
        .head_x_o   (head_x_w),
        .head_y_o   (head_y_w),
        .a_x_i      (nx_w[XW-1:0]),
        .a_y_i      (ny_w[YW-1:0]),
        .a_cnt_i    (col_cnt),
        .a_hit_o    (self_w),
        .b_x_i      (q_x),
        .b_y_i      (q_y),
        .b_cnt_i    (len_q),
        .b_hit_o    (q_hit_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause || esc)
                        state_d = ST_PAUSED;
                    else if (collide)
                        state_d = ST_OVER;
                end
                ST_PAUSED: begin
                    if (!pause && !esc && resume)
                        state_d = ST_RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // On a move the heading becomes pend_dir, so reversal is judged against
    // that; otherwise a turn latched in the move cycle could fold the snake
    // back onto its own neck on the next tick.
    always_comb begin
        ref_dir     = do_move ? pend_dir_q : cur_dir_q;
        pend_dir_d  = is_reverse(dir_in, ref_dir) ? pend_dir_q : dir_in;
        cur_dir_d   = do_move ? pend_dir_q : cur_dir_q;
        grow_pend_d = do_move ? grow : (grow_pend_q | grow);
        hptr_d      = do_move ? (hptr_q - PW'(1)) : hptr_q;
        len_d       = len_q;
        if (do_move && grow_pend_q && (len_q < LEN_MAX))
            len_d = len_q + LW'(1);
        q_head_d    = (head_x_w == q_x) && (head_y_w == q_y);
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cur_dir_q   <= DIR_RIGHT;
            pend_dir_q  <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            len_q       <= LEN_INIT;
            hptr_q      <= '0;
            q_hit_q     <= 1'b0;
            q_head_q    <= 1'b0;
        end else begin
            cur_dir_q   <= cur_dir_d;
            pend_dir_q  <= pend_dir_d;
            grow_pend_q <= grow_pend_d;
            len_q       <= len_d;
            hptr_q      <= hptr_d;
            q_hit_q     <= q_hit_d;
            q_head_q    <= q_head_d;
        end
    end

    assign q_hit     = q_hit_q;
    assign q_head    = q_head_q;
    assign head_x    = head_x_w;
    assign head_y    = head_y_w;
    assign length    = len_q;
    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

    logic       clk = 1'b0;
    logic       reset, tick, start, pause, resume, esc, grow;
    logic [1:0] dir_in;
    logic [5:0] q_x, q_y;
    logic       q_hit, q_head, running, game_over;
    logic [5:0] head_x, head_y;
    logic [4:0] length;

    int n_pass = 0;
    int n_total = 0;

    snake_body_engine dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .pause     (pause),
        .resume    (resume),
        .esc       (esc),
        .dir_in    (dir_in),
        .grow      (grow),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_hit     (q_hit),
        .q_head    (q_head),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .running   (running),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Body as a plain list: index 0 is the head, shifted on every move.
    int m_x [0:16];
    int m_y [0:16];
    int m_len, m_state, m_cur, m_pend;   // state: 0 idle, 1 run, 2 paused, 3 over
    bit m_gp, m_valid = 0;
    bit e_qhit, e_qhead;
    int t_nx, t_ny, t_lim, t_ref, t_newlen;
    bit t_coll, t_moved, t_qh, t_qhd;

    function automatic int dx_of(input int d);
        return (d == 2) ? 1 : (d == 3) ? -1 : 0;
    endfunction
    function automatic int dy_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? -1 : 0;
    endfunction
    function automatic bit opposite(input int a, input int b);
        return (a ^ b) == 1;
    endfunction

    task automatic m_init();
        m_len = 4;
        for (int i = 0; i < 4; i++) begin
            m_x[i] = 3 - i;
            m_y[i] = 13;
        end
        m_cur = 2; m_pend = 2; m_gp = 0;
        e_qhit = 0; e_qhead = 0;
    endtask

    always @(posedge clk) begin
        t_qh = 0;
        for (int i = 0; i < m_len; i++)
            if (m_x[i] == int'(q_x) && m_y[i] == int'(q_y)) t_qh = 1;
        t_qhd = (m_x[0] == int'(q_x)) && (m_y[0] == int'(q_y));
        if (reset) begin
            m_init(); m_state = 0; m_valid = 1;
        end else if (start) begin
            m_init(); m_state = 1;
        end else begin
            e_qhit = t_qh; e_qhead = t_qhd; t_moved = 0;
            if (m_state == 1) begin
                if (pause || esc) m_state = 2;
                else if (tick) begin
                    t_nx = m_x[0] + dx_of(m_pend);
                    t_ny = m_y[0] + dy_of(m_pend);
                    t_coll = (t_nx < 0) || (t_nx > 63) || (t_ny < 0) || (t_ny > 47);
                    t_lim = m_gp ? m_len : m_len - 1;
                    for (int i = 0; i < t_lim; i++)
                        if (m_x[i] == t_nx && m_y[i] == t_ny) t_coll = 1;
                    if (t_coll) m_state = 3;
                    else begin
                        t_newlen = (m_gp && m_len < 16) ? m_len + 1 : m_len;
                        for (int i = t_newlen - 1; i > 0; i--) begin
                            m_x[i] = m_x[i-1];
                            m_y[i] = m_y[i-1];
                        end
                        m_x[0] = t_nx; m_y[0] = t_ny;
                        m_len = t_newlen;
                        t_moved = 1;
                    end
                end
            end else if (m_state == 2 && !pause && !esc && resume) begin
                m_state = 1;
            end
            t_ref = t_moved ? m_pend : m_cur;
            if (t_moved) m_cur = m_pend;
            if (!opposite(int'(dir_in), t_ref)) m_pend = int'(dir_in);
            m_gp = t_moved ? grow : (m_gp | grow);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("head_x",    int'(head_x),    m_x[0]);
            chk("head_y",    int'(head_y),    m_y[0]);
            chk("length",    int'(length),    m_len);
            chk("running",   int'(running),   int'(m_state == 1));
            chk("game_over", int'(game_over), int'(m_state == 3));
            chk("q_hit",     int'(q_hit),     int'(e_qhit));
            chk("q_head",    int'(q_head),    int'(e_qhead));
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            reset = 0; tick = 0; start = 0; pause = 0; resume = 0; esc = 0; grow = 0;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1;
            go(1);
        end
    endtask

    task automatic restart();
        dir_in = 2'b10; start = 1; go(1);
    endtask

    initial begin
        reset = 1; tick = 0; start = 0; pause = 0; resume = 0; esc = 0; grow = 0;
        dir_in = 2'b10; q_x = 0; q_y = 0;
        go(1);
        reset = 1; go(1);
        chk("rst_head_x", int'(head_x), 3);
        chk("rst_head_y", int'(head_y), 13);
        chk("rst_len",    int'(length), 4);
        chk("rst_run",    int'(running), 0);
        chk("rst_qhit",   int'(q_hit), 0);

        // three moves right, then occupancy queries
        restart();
        ticks(3);
        chk("t1_head_x", int'(head_x), 6);
        chk("t1_head_y", int'(head_y), 13);
        chk("t1_model_head", m_x[0], 6);
        q_x = 3; q_y = 13; go(1);
        chk("t1_q3_hit", int'(q_hit), 1);
        q_x = 2; q_y = 13; go(1);
        chk("t1_q2_hit", int'(q_hit), 0);
        q_x = 6; q_y = 13; go(1);
        chk("t1_q6_head", int'(q_head), 1);

        // right wall
        ticks(57);
        chk("wallr_x", int'(head_x), 63);
        chk("wallr_run", int'(running), 1);
        ticks(1);
        chk("wallr_over", int'(game_over), 1);
        chk("wallr_hold", int'(head_x), 63);

        // top wall
        restart();
        dir_in = 2'b01; go(1);
        ticks(13);
        chk("wallu_y", int'(head_y), 0);
        ticks(1);
        chk("wallu_over", int'(game_over), 1);
        chk("wallu_hold_y", int'(head_y), 0);
        chk("wallu_hold_x", int'(head_x), 3);

        // reverse ignored, then a legal turn
        restart();
        dir_in = 2'b11; tick = 1; go(1);
        chk("rev_x", int'(head_x), 4);
        dir_in = 2'b01; go(1);
        ticks(1);
        chk("turn_y", int'(head_y), 12);
        chk("turn_x", int'(head_x), 4);

        // growth and saturation
        restart();
        grow = 1; tick = 1; go(1);
        chk("grow_delay", int'(length), 4);
        ticks(1);
        chk("grow_apply", int'(length), 5);
        repeat (11) begin
            grow = 1; go(1);
            ticks(1);
        end
        chk("grow_16", int'(length), 16);
        chk("grow_model_16", m_len, 16);
        grow = 1; go(1);
        ticks(2);
        chk("grow_sat", int'(length), 16);

        // box into vacating tail cell: legal
        restart();
        dir_in = 2'b00; go(1); ticks(1);
        dir_in = 2'b11; go(1); ticks(1);
        dir_in = 2'b01; go(1); ticks(1);
        chk("tail_run", int'(running), 1);
        chk("tail_x", int'(head_x), 2);
        chk("tail_y", int'(head_y), 13);

        // same box at length 5: head hits body
        restart();
        grow = 1; go(1);
        dir_in = 2'b00; go(1); ticks(1);
        dir_in = 2'b11; go(1); ticks(1);
        dir_in = 2'b01; go(1); ticks(1);
        chk("self_over", int'(game_over), 1);
        chk("self_hold_y", int'(head_y), 14);
        chk("self_len", int'(length), 5);

        // start from OVER
        restart();
        chk("reinit_run", int'(running), 1);
        chk("reinit_over", int'(game_over), 0);
        chk("reinit_x", int'(head_x), 3);
        chk("reinit_len", int'(length), 4);

        // pause with tick, resume, tick
        pause = 1; tick = 1; go(1);
        chk("pause_run", int'(running), 0);
        chk("pause_x", int'(head_x), 3);
        resume = 1; go(1);
        chk("resume_run", int'(running), 1);
        ticks(1);
        chk("resume_x", int'(head_x), 4);

        // randomized phase, checked cycle-by-cycle against the model
        for (int c = 0; c < 5000; c++) begin
            tick   = ($urandom_range(0, 9) < 4);
            grow   = ($urandom_range(0, 5) == 0);
            pause  = ($urandom_range(0, 39) == 0);
            esc    = ($urandom_range(0, 79) == 0);
            resume = ($urandom_range(0, 4) == 0);
            start  = ($urandom_range(0, 99) == 0) ||
                     ((m_state == 3 || m_state == 0) && $urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) dir_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                int k;
                k = $urandom_range(0, m_len - 1);
                q_x = 6'(m_x[k]);
                q_y = 6'(m_y[k]);
            end else begin
                q_x = 6'($urandom_range(0, 63));
                q_y = 6'($urandom_range(0, 63));
            end
            go(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
